// File: rtl/axi_rd_arbiter_if.sv
// AXI-lite read channel bundle (AR + R) shared by the IFU, LSU and memory ports.
// Handshake: a beat transfers on a cycle where valid && ready; valid never waits on ready.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI-lite read arbiter (IFU = 0, LSU = 1), one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority (LSU wins).
module axi_rd_arbiter (
  input  logic             clk,
  input  logic             rst,
  axi_rd_arbiter_if.slave  ifu,
  axi_rd_arbiter_if.slave  lsu,
  axi_rd_arbiter_if.master m,
  output logic [1:0]       dbg_state,
  output logic             dbg_gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   gnt;
  logic   any_req;
  logic   win;
  logic   sel_arvalid;
  logic   sel_rready;

  assign any_req     = ifu.arvalid | lsu.arvalid;
  assign sel_arvalid = gnt ? lsu.arvalid : ifu.arvalid;
  assign sel_rready  = gnt ? lsu.rready  : ifu.rready;

`ifdef ARB_ROUND_ROBIN_EN
  // last starts at LSU so the first tie after reset goes to the IFU
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last <= win;
    end
  end

  assign win = (ifu.arvalid && lsu.arvalid) ? ~last : lsu.arvalid;
`else
  assign win = lsu.arvalid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        gnt <= win;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    if (sel_arvalid && m.arready) state_nxt = DATA;
      DATA:    if (m.rvalid && sel_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pass-through is gated only by registered state/gnt, so IDLE never combines arvalid into arready
  always_comb begin
    m.araddr    = '0;
    m.arvalid   = 1'b0;
    m.rready    = 1'b0;
    ifu.arready = 1'b0;
    ifu.rdata   = '0;
    ifu.rresp   = 2'b00;
    ifu.rvalid  = 1'b0;
    lsu.arready = 1'b0;
    lsu.rdata   = '0;
    lsu.rresp   = 2'b00;
    lsu.rvalid  = 1'b0;
    case (state)
      ADDR: begin
        m.araddr  = gnt ? lsu.araddr : ifu.araddr;
        m.arvalid = sel_arvalid;
        if (gnt) lsu.arready = m.arready;
        else     ifu.arready = m.arready;
      end
      DATA: begin
        m.rready = sel_rready;
        if (gnt) begin
          lsu.rdata  = m.rdata;
          lsu.rresp  = m.rresp;
          lsu.rvalid = m.rvalid;
        end else begin
          ifu.rdata  = m.rdata;
          ifu.rresp  = m.rresp;
          ifu.rvalid = m.rvalid;
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state;
  assign dbg_gnt   = gnt;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed and random read traffic against a transaction-level model.
// Expected tie-break follows ARB_ROUND_ROBIN_EN, so the bench works in either build.
module tb_axi_rd_arbiter;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic       dbg_gnt;

  axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_bus ();
  axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
  axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_bus ();

  axi_rd_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ifu       (ifu_bus),
    .lsu       (lsu_bus),
    .m         (m_bus),
    .dbg_state (dbg_state),
    .dbg_gnt   (dbg_gnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [34:0] exp_q[$];   // {master, rresp, rdata} per granted transaction
  bit          ifu_pend, lsu_pend;
  logic [31:0] ifu_addr, lsu_addr;
`ifdef ARB_ROUND_ROBIN_EN
  bit          last_m;
`endif

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : ({a[15:0], a[31:16]} ^ 32'hA5A5_5A5A);
  endfunction

  function automatic bit pick(input bit iv, input bit lv);
    if (iv && lv) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !last_m;
`else
      return 1'b1;
`endif
    end
    return lv;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    ifu_bus.arvalid = ifu_pend;
    ifu_bus.araddr  = ifu_addr;
    lsu_bus.arvalid = lsu_pend;
    lsu_bus.araddr  = lsu_addr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, dbg_state, 2'd0);
    chk({tag, "_m_arvalid"}, m_bus.arvalid, 1'b0);
    chk({tag, "_m_araddr"}, m_bus.araddr, 32'h0);
    chk({tag, "_m_rready"}, m_bus.rready, 1'b0);
    chk({tag, "_arready"}, {ifu_bus.arready, lsu_bus.arready}, 2'b00);
    chk({tag, "_rvalid"}, {ifu_bus.rvalid, lsu_bus.rvalid}, 2'b00);
    chk({tag, "_rdata"}, {ifu_bus.rdata, lsu_bus.rdata}, 64'h0);
    chk({tag, "_rresp"}, {ifu_bus.rresp, lsu_bus.rresp}, 4'h0);
  endtask

  // One full transaction starting in an IDLE cycle with requests already pending.
  task automatic serve(input int ar_dly, input int r_dly, input int rr_dly,
                       input logic [1:0] resp, input int drop_at, input bit raise_other);
    bit          w;
    bit          done;
    logic [31:0] a;
    logic [31:0] sl_addr;
    logic [34:0] e;
    int          cyc;
    int          exp_cyc;
    w = pick(ifu_pend, lsu_pend);
`ifdef ARB_ROUND_ROBIN_EN
    last_m = w;
`endif
    a = w ? lsu_addr : ifu_addr;
    exp_q.push_back({w, resp, mem_data(a)});
    sl_addr = 32'h0;
    cyc = 0;
    drive_reqs();
    #1;
    chk("idle_state", dbg_state, 2'd0);
    chk("idle_no_arready", {ifu_bus.arready, lsu_bus.arready}, 2'b00);
    chk("idle_m_arvalid", m_bus.arvalid, 1'b0);
    next_cycle(); cyc++;
    for (int k = 0; k <= ar_dly; k++) begin
      if (raise_other && k == 0) begin
        if (w && !ifu_pend) begin ifu_pend = 1'b1; ifu_addr = $urandom & 32'hFFFF_FFFC; end
        if (!w && !lsu_pend) begin lsu_pend = 1'b1; lsu_addr = $urandom & 32'hFFFF_FFFC; end
      end
      drive_reqs();
      if (k == drop_at) begin
        if (w) lsu_bus.arvalid = 1'b0;
        else   ifu_bus.arvalid = 1'b0;
      end
      m_bus.arready = (k == ar_dly);
      #1;
      chk("addr_state", dbg_state, 2'd1);
      chk("addr_m_araddr", m_bus.araddr, a);
      chk("addr_m_arvalid", m_bus.arvalid, (k != drop_at));
      chk("addr_gnt_arready", w ? lsu_bus.arready : ifu_bus.arready, m_bus.arready);
      chk("addr_other_arready", w ? ifu_bus.arready : lsu_bus.arready, 1'b0);
      chk("addr_rvalid", {ifu_bus.rvalid, lsu_bus.rvalid}, 2'b00);
      if (k == ar_dly) sl_addr = m_bus.araddr;
      next_cycle(); cyc++;
    end
    if (w) lsu_pend = 1'b0;
    else   ifu_pend = 1'b0;
    drive_reqs();
    m_bus.arready = 1'b0;
    done = 1'b0;
    for (int j = 0; j < 40 && !done; j++) begin
      m_bus.rvalid = (j >= r_dly);
      m_bus.rdata  = mem_data(sl_addr);
      m_bus.rresp  = resp;
      if (w) begin lsu_bus.rready = (j >= rr_dly); ifu_bus.rready = !(j >= rr_dly); end
      else   begin ifu_bus.rready = (j >= rr_dly); lsu_bus.rready = !(j >= rr_dly); end
      #1;
      chk("data_state", dbg_state, 2'd2);
      chk("data_gnt_rvalid", w ? lsu_bus.rvalid : ifu_bus.rvalid, m_bus.rvalid);
      chk("data_m_rready", m_bus.rready, (j >= rr_dly));
      chk("data_other_r", w ? {ifu_bus.rvalid, ifu_bus.rresp, ifu_bus.rdata}
                            : {lsu_bus.rvalid, lsu_bus.rresp, lsu_bus.rdata}, 35'h0);
      chk("data_arready", {ifu_bus.arready, lsu_bus.arready, m_bus.arvalid}, 3'b000);
      if (m_bus.rvalid && (j >= rr_dly)) begin
        e = exp_q.pop_front();
        chk("sb_master", {lsu_bus.rvalid, ifu_bus.rvalid}, e[34] ? 2'b10 : 2'b01);
        chk("sb_rresp", w ? lsu_bus.rresp : ifu_bus.rresp, e[33:32]);
        chk("sb_rdata", w ? lsu_bus.rdata : ifu_bus.rdata, e[31:0]);
        done = 1'b1;
      end
      next_cycle(); cyc++;
    end
    chk("data_timeout", done, 1'b1);
    m_bus.rvalid   = 1'b0;
    m_bus.rdata    = 32'h0;
    m_bus.rresp    = 2'b00;
    ifu_bus.rready = 1'b0;
    lsu_bus.rready = 1'b0;
    exp_cyc = 3 + ar_dly + ((r_dly > rr_dly) ? r_dly : rr_dly);
    chk("txn_cycles", cyc, exp_cyc);
    chk("back_to_idle", dbg_state, 2'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0] rsel;
    ifu_pend = 1'b0; lsu_pend = 1'b0;
    ifu_addr = 32'h0; lsu_addr = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
    last_m = 1'b1;
`endif
    drive_reqs();
    ifu_bus.rready = 1'b0; lsu_bus.rready = 1'b0;
    m_bus.arready = 1'b1; m_bus.rvalid = 1'b1;
    m_bus.rdata = 32'hDEAD_BEEF; m_bus.rresp = 2'b11;
    rst = 1'b1;
    repeat (2) next_cycle();
    chk_all_zero("reset");
    chk("reset_gnt", dbg_gnt, 1'b0);
    m_bus.arready = 1'b0; m_bus.rvalid = 1'b0;
    m_bus.rdata = 32'h0; m_bus.rresp = 2'b00;
    rst = 1'b0;
    next_cycle();

    // IFU-only read at minimum latency
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0000;
    serve(0, 0, 0, 2'b00, -1, 1'b0);

    // Simultaneous requests, twice (four grants)
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_pend = 1'b1; lsu_addr = 32'h8000_1000;
    serve(0, 0, 0, 2'b00, -1, 1'b0);
    serve(0, 0, 0, 2'b00, -1, 1'b0);
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0008;
    lsu_pend = 1'b1; lsu_addr = 32'h8000_1004;
    serve(0, 0, 0, 2'b00, -1, 1'b0);
    serve(0, 0, 0, 2'b00, -1, 1'b0);

    // Slave stalls on an LSU read while the IFU waits
    lsu_pend = 1'b1; lsu_addr = 32'h8000_2000;
    serve(5, 3, 2, 2'b00, -1, 1'b1);
    serve(0, 0, 0, 2'b00, -1, 1'b0);

    // Error response to the IFU, then a normal read
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0010;
    serve(1, 1, 0, 2'b10, -1, 1'b0);
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0014;
    serve(0, 0, 0, 2'b00, -1, 1'b0);

    // Granted master drops arvalid while the slave stalls
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0020;
    serve(3, 0, 0, 2'b00, 1, 1'b0);

    // Reset while a response is pending
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0030;
    drive_reqs();
    next_cycle();
    m_bus.arready = 1'b1;
    next_cycle();
    ifu_pend = 1'b0; drive_reqs();
    m_bus.arready = 1'b0;
    m_bus.rvalid = 1'b1; m_bus.rdata = 32'h1234_5678; m_bus.rresp = 2'b11;
    #1;
    chk("rst_pre_state", dbg_state, 2'd2);
    chk("rst_pre_rvalid", ifu_bus.rvalid, 1'b1);
    rst = 1'b1;
    next_cycle();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    m_bus.rvalid = 1'b0; m_bus.rdata = 32'h0; m_bus.rresp = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
    last_m = 1'b1;
`endif
    ifu_pend = 1'b1; ifu_addr = 32'h8000_0040;
    serve(0, 0, 0, 2'b00, -1, 1'b0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      rsel = 2'($urandom_range(1, 3));
      if (rsel[0] && !ifu_pend) begin ifu_pend = 1'b1; ifu_addr = $urandom & 32'hFFFF_FFFC; end
      if (rsel[1] && !lsu_pend) begin lsu_pend = 1'b1; lsu_addr = $urandom & 32'hFFFF_FFFC; end
      serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
            2'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 2; i++) begin
      if (ifu_pend || lsu_pend) serve(0, 1, 1, 2'b01, -1, 1'b0);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master AXI-lite read-channel arbiter that shares the single memory read port between the instruction-fetch unit (master 0) and the load/store unit (master 1). It sits between the IFU/LSU read interfaces and the memory/SRAM slave. It grants one master at a time, allows one outstanding transaction, and routes the R response back to the granted master only. Write channels bypass this block.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ifu_araddr  in  ADDR_W  IFU read address
- ifu_arvalid  in  1  IFU address valid
- ifu_arready  out  1  address accepted for IFU
- ifu_rdata  out  DATA_W  read data to IFU
- ifu_rresp  out  2  read response to IFU
- ifu_rvalid  out  1  read data valid to IFU
- ifu_rready  in  1  IFU ready for data
- lsu_araddr  in  ADDR_W  LSU read address
- lsu_arvalid  in  1  LSU address valid
- lsu_arready  out  1  address accepted for LSU
- lsu_rdata  out  DATA_W  read data to LSU
- lsu_rresp  out  2  read response to LSU
- lsu_rvalid  out  1  read data valid to LSU
- lsu_rready  in  1  LSU ready for data
- m_araddr  out  ADDR_W  address to slave
- m_arvalid  out  1  address valid to slave
- m_arready  in  1  slave address ready
- m_rdata  in  DATA_W  slave read data
- m_rresp  in  2  slave read response
- m_rvalid  in  1  slave data valid
- m_rready  out  1  ready to slave

## Operation
- FSM states: IDLE, ADDR, DATA. Grant register `gnt` (0 = IFU, 1 = LSU) is written only in IDLE.
- IDLE: if any arvalid is high, latch the winner into `gnt` and go to ADDR. Otherwise stay. All arready/rvalid outputs and m_arvalid/m_rready are 0.
- ADDR: m_araddr/m_arvalid come from the granted master. The granted master's arready = m_arready; the other master's arready = 0. On m_arvalid && m_arready, go to DATA.
- DATA: the granted master receives m_rdata/m_rresp/m_rvalid, and m_rready = granted master's rready. On m_rvalid && m_rready, go to IDLE. The other master sees rvalid = 0 and rdata/rresp = 0.
- Nonzero rresp (SLVERR/DECERR) is forwarded unchanged; the arbiter takes no other action.
- A non-granted master holding arvalid waits; its request is never dropped, and arbitration re-evaluates in the next IDLE.
- If the granted master deasserts arvalid in ADDR, m_arvalid follows it. The state holds in ADDR and does not re-arbitrate.

## Timing
- Reset: state = IDLE, gnt = 0. All outputs are 0, including m_araddr and both rdata/rresp.
- Reset mid-transaction: state returns to IDLE and any in-flight response is abandoned. m_rready is 0 in IDLE, so the slave must also be reset.
- Minimum latency: request seen in IDLE at cycle 0. m_arvalid is asserted at cycle 1. With m_arready high at cycle 1 and m_rvalid at cycle 2, the master gets rvalid at cycle 2 and the next grant is decided at cycle 3.
- Back-to-back transactions are therefore spaced at 3 cycles minimum; there is no IDLE bypass.
- ADDR- and DATA-phase outputs are combinational pass-through gated by registered state/gnt. There are no combinational paths from arvalid to arready in IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN undefined: fixed priority. When both arvalid are high in IDLE, the LSU wins.
- ARB_ROUND_ROBIN_EN defined: a `last` register holds the most recent grant (reset value = LSU). On a tie, the master not equal to `last` wins, and `last` updates at each grant. A single requester always wins regardless of `last`.

## Test plan
- IFU-only read: ifu_arvalid=1, addr 0x8000_0000; slave returns 0x0000_0413 with rresp=0 -> ifu_rvalid=1 with that data; lsu_rvalid stays 0 throughout.
- Simultaneous requests, macro undefined: both arvalid=1 at the same cycle (IFU 0x8000_0004, LSU 0x8000_1000) -> LSU address issued first, then IFU; each receives its own data.
- Simultaneous requests, ARB_ROUND_ROBIN_EN defined, repeated 4 times -> grant order IFU, LSU, IFU, LSU.
- Slave stalls: m_arready=0 for 5 cycles, then m_rvalid delayed 3 cycles, with LSU rready=0 for 2 cycles -> m_araddr held stable; data handed over only when lsu_rready=1; the IFU is not granted meanwhile.
- Error response: slave returns rresp=2'b10 to the IFU -> ifu_rresp=2'b10, then FSM returns to IDLE and the next request is served normally.
- Reset asserted while in DATA -> next cycle all outputs are 0 and state is IDLE; a fresh IFU request then completes at minimum latency.
